multicycle_ctrl_fsm: RTL

- Parametrised multicycle RV32 control FSM driving the shared single-port datapath (IR, A/B, AOut, MDR, ALU, shifter, PC).
- Memory accesses use a req/ready handshake with programmable timeout, replacing fixed-latency access.
- Branch resolution is internal: one resolved pc_write replaces per-condition enables.
- Illegal opcodes and memory timeouts enter a sticky trap state.

---
 rtl/ctrl_pkg.sv | 145 ++++++++++++++
 rtl/mem_wait_timer.sv | 38 +++
 rtl/multicycle_ctrl_fsm.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle RV32 controller: states, opcodes,
// datapath select codes and the instruction pre-decode used in DECODE.
package ctrl_pkg;

   typedef enum logic [4:0] {
      S_IDLE = 5'd0,
      S_FETCH_REQ,
      S_FETCH_WAIT,
      S_DECODE,
      S_EXEC_R,
      S_EXEC_I,
      S_ALU_WB,
      S_SHIFT_WB,
      S_ADDR_CALC,
      S_MEM_RD_REQ,
      S_MEM_RD_WAIT,
      S_LOAD_WB,
      S_MEM_WR_REQ,
      S_MEM_WR_WAIT,
      S_BRANCH,
      S_JAL,
      S_JALR_CALC,
      S_JALR_JUMP,
      S_LUI_WB,
      S_HALT,
      S_TRAP
   } state_e;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_SYS   = 7'b1110011;
   localparam logic [6:0] F7_BASE  = 7'b0000000;
   localparam logic [6:0] F7_ALT   = 7'b0100000;

   localparam logic [2:0] ALU_PASS = 3'd0;
   localparam logic [2:0] ALU_ADD  = 3'd1;
   localparam logic [2:0] ALU_SUB  = 3'd2;
   localparam logic [2:0] ALU_AND  = 3'd3;
   localparam logic [2:0] ALU_SLT  = 3'd7;

   localparam logic [2:0] WB_AOUT  = 3'd0;
   localparam logic [2:0] WB_MDR   = 3'd1;
   localparam logic [2:0] WB_IMM   = 3'd2;
   localparam logic [2:0] WB_SHIFT = 3'd3;
   localparam logic [2:0] WB_PC    = 3'd4;

   localparam logic [1:0] SRCA_PC   = 2'd0;
   localparam logic [1:0] SRCA_A    = 2'd1;
   localparam logic [1:0] SRCB_B    = 2'd0;
   localparam logic [1:0] SRCB_4    = 2'd1;
   localparam logic [1:0] SRCB_IMM  = 2'd2;
   localparam logic [1:0] SRCB_IMM1 = 2'd3;

   localparam logic [1:0] SH_SLL = 2'd0;
   localparam logic [1:0] SH_SRL = 2'd1;
   localparam logic [1:0] SH_SRA = 2'd2;

   localparam logic [1:0] PCS_ALU  = 2'd0;
   localparam logic [1:0] PCS_AOUT = 2'd1;
   localparam logic [1:0] PCS_JALR = 2'd2;

   localparam logic [1:0] TRAP_NONE = 2'd0;
   localparam logic [1:0] TRAP_ILL  = 2'd1;
   localparam logic [1:0] TRAP_TMO  = 2'd2;

   typedef struct packed {
      state_e     nxt;
      logic [2:0] fct;
      logic [1:0] sh;
      logic       st;
      logic       slt;
   } dec_t;

   function automatic dec_t decode(input logic [31:0] ir,
                                   input logic [31:0] nop);
      dec_t       d;
      logic [2:0] f3;
      logic [6:0] f7;
      f3    = ir[14:12];
      f7    = ir[31:25];
      d.nxt = S_TRAP;
      d.fct = ALU_ADD;
      d.sh  = SH_SLL;
      d.st  = 1'b0;
      d.slt = 1'b0;
      if (ir == nop) begin
         d.nxt = S_FETCH_REQ;
      end else begin
         unique case (ir[6:0])
            OP_R: begin
               if (f7 == F7_BASE && f3 == 3'b000) begin
                  d.nxt = S_EXEC_R;
               end else if (f7 == F7_BASE && f3 == 3'b010) begin
                  d.nxt = S_EXEC_R;
                  d.fct = ALU_SLT;
                  d.slt = 1'b1;
               end else if (f7 == F7_BASE && f3 == 3'b111) begin
                  d.nxt = S_EXEC_R;
                  d.fct = ALU_AND;
               end else if (f7 == F7_ALT && f3 == 3'b000) begin
                  d.nxt = S_EXEC_R;
                  d.fct = ALU_SUB;
               end
            end
            OP_IMM: begin
               if (f3 == 3'b000) begin
                  d.nxt = S_EXEC_I;
               end else if (f3 == 3'b010) begin
                  d.nxt = S_EXEC_I;
                  d.fct = ALU_SLT;
                  d.slt = 1'b1;
               end else if (f3 == 3'b001) begin
                  d.nxt = S_SHIFT_WB;
               end else if (f3 == 3'b101) begin
                  d.nxt = S_SHIFT_WB;
                  d.sh  = ir[30] ? SH_SRA : SH_SRL;
               end
            end
            OP_LOAD:  d.nxt = S_ADDR_CALC;
            OP_STORE: begin
               d.nxt = S_ADDR_CALC;
               d.st  = 1'b1;
            end
            OP_BR: begin
               if (f3[1] == 1'b0) d.nxt = S_BRANCH;
            end
            OP_JAL:  d.nxt = S_JAL;
            OP_JALR: begin
               if (f3 == 3'b000) d.nxt = S_JALR_CALC;
            end
            OP_LUI:  d.nxt = S_LUI_WB;
            OP_SYS:  d.nxt = S_HALT;
            default: d.nxt = S_TRAP;
         endcase
      end
      return d;
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts unready memory cycles from a request and flags a timeout
// on the cycle the count hits TIMEOUT_CYC-1 without ready (0 disables).
module mem_wait_timer #(
   parameter int unsigned TIMEOUT_CYC = 16
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic start_i,
   input  logic busy_i,
   input  logic ready_i,
   output logic timeout_o
);

   localparam int unsigned CW =
      (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CW-1:0] LIM =
      CW'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

   logic [CW-1:0] cnt_q, cnt_d, cnt;
   logic          act;

   // A fresh request always sees count zero, whatever was left over.
   assign cnt = start_i ? '0 : cnt_q;
   assign act = (start_i | busy_i) & ~ready_i;

   always_comb begin
      cnt_d = '0;
      if (act) cnt_d = (cnt == '1) ? cnt : cnt + CW'(1);
   end

   assign timeout_o = (TIMEOUT_CYC != 0) && act && (cnt == LIM);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle RV32 control FSM with handshaked memory and sticky traps.
// Define CTRL_PERF_CNT_EN to add the cyc_cnt/ret_cnt counters.
module multicycle_ctrl_fsm
   import ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 16,
   parameter logic [31:0] NOP_WORD    = 32'h00000013,
   parameter int unsigned STATE_W     = 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [31:0]        instr,
   input  logic               mem_ready,
   input  logic               alu_zero,
   input  logic               alu_lt,
   output logic [STATE_W-1:0] state_out,
   output logic               mem_req,
   output logic               mem_we,
   output logic               ir_load,
   output logic               load_a,
   output logic               load_b,
   output logic               load_aout,
   output logic               load_mdr,
   output logic               reg_write,
   output logic [2:0]         wb_sel,
   output logic [1:0]         alu_src_a,
   output logic [1:0]         alu_src_b,
   output logic [2:0]         alu_fct,
   output logic [1:0]         shift,
   output logic               pc_write,
   output logic [1:0]         pc_src,
   output logic               halted,
   output logic [1:0]         trap_cause
`ifdef CTRL_PERF_CNT_EN
  ,output logic [31:0]        cyc_cnt,
   output logic [31:0]        ret_cnt
`endif
);

   state_e     state_q, state_d;
   logic [1:0] trap_q, trap_d;
   logic [2:0] fct_q;
   logic [1:0] sh_q;
   logic       st_q, slt_q, neg_q, lt_q;
   logic       req_st, wait_st, tmo;
   dec_t       dec;

   assign dec     = decode(instr, NOP_WORD);
   assign req_st  = (state_q == S_FETCH_REQ) || (state_q == S_MEM_RD_REQ) ||
                    (state_q == S_MEM_WR_REQ);
   assign wait_st = (state_q == S_FETCH_WAIT) || (state_q == S_MEM_RD_WAIT) ||
                    (state_q == S_MEM_WR_WAIT);

   mem_wait_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_tmr (
      .clk_i    (clk),
      .rst_ni   (reset),
      .start_i  (req_st),
      .busy_i   (wait_st),
      .ready_i  (mem_ready),
      .timeout_o(tmo)
   );

   always_comb begin
      state_d = state_q;
      trap_d  = trap_q;
      unique case (state_q)
         S_IDLE: state_d = S_FETCH_REQ;
         S_FETCH_REQ, S_FETCH_WAIT:
            state_d = mem_ready ? S_DECODE : (tmo ? S_TRAP : S_FETCH_WAIT);
         S_DECODE: state_d = dec.nxt;
         S_EXEC_R, S_EXEC_I: state_d = slt_q ? S_FETCH_REQ : S_ALU_WB;
         S_ADDR_CALC: state_d = st_q ? S_MEM_WR_REQ : S_MEM_RD_REQ;
         S_MEM_RD_REQ, S_MEM_RD_WAIT:
            state_d = mem_ready ? S_LOAD_WB : (tmo ? S_TRAP : S_MEM_RD_WAIT);
         S_MEM_WR_REQ, S_MEM_WR_WAIT:
            state_d = mem_ready ? S_FETCH_REQ : (tmo ? S_TRAP : S_MEM_WR_WAIT);
         S_JALR_CALC: state_d = S_JALR_JUMP;
         S_HALT, S_TRAP: state_d = state_q;
         default: state_d = S_FETCH_REQ;
      endcase
      if (state_d == S_TRAP && state_q != S_TRAP)
         trap_d = (state_q == S_DECODE) ? TRAP_ILL : TRAP_TMO;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         trap_q  <= TRAP_NONE;
         fct_q   <= ALU_PASS;
         sh_q    <= SH_SLL;
         st_q    <= 1'b0;
         slt_q   <= 1'b0;
         neg_q   <= 1'b0;
         lt_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         trap_q  <= trap_d;
         if (state_q == S_DECODE) begin
            fct_q <= dec.fct;
            sh_q  <= dec.sh;
            st_q  <= dec.st;
            slt_q <= dec.slt;
            neg_q <= instr[12];
            lt_q  <= instr[14];
         end
      end
   end

   always_comb begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      ir_load   = 1'b0;
      load_a    = 1'b0;
      load_b    = 1'b0;
      load_aout = 1'b0;
      load_mdr  = 1'b0;
      reg_write = 1'b0;
      wb_sel    = WB_AOUT;
      alu_src_a = SRCA_PC;
      alu_src_b = SRCB_B;
      alu_fct   = ALU_PASS;
      shift     = SH_SLL;
      pc_write  = 1'b0;
      pc_src    = PCS_ALU;
      halted    = 1'b0;
      unique case (state_q)
         S_FETCH_REQ, S_FETCH_WAIT: begin
            mem_req   = 1'b1;
            ir_load   = mem_ready;
            pc_write  = mem_ready;
            alu_src_b = SRCB_4;
            alu_fct   = ALU_ADD;
         end
         S_DECODE: begin
            load_a    = 1'b1;
            load_b    = 1'b1;
            load_aout = 1'b1;
            alu_src_b = SRCB_IMM1;
            alu_fct   = ALU_ADD;
         end
         S_EXEC_R, S_EXEC_I: begin
            alu_src_a = SRCA_A;
            alu_src_b = (state_q == S_EXEC_I) ? SRCB_IMM : SRCB_B;
            alu_fct   = fct_q;
            load_aout = 1'b1;
            reg_write = slt_q;
            wb_sel    = slt_q ? WB_IMM : WB_AOUT;
         end
         S_ALU_WB: reg_write = 1'b1;
         S_SHIFT_WB: begin
            reg_write = 1'b1;
            wb_sel    = WB_SHIFT;
            shift     = sh_q;
         end
         S_ADDR_CALC, S_JALR_CALC: begin
            alu_src_a = SRCA_A;
            alu_src_b = SRCB_IMM;
            alu_fct   = ALU_ADD;
            load_aout = 1'b1;
         end
         S_MEM_RD_REQ, S_MEM_RD_WAIT: begin
            mem_req  = 1'b1;
            load_mdr = mem_ready;
         end
         S_LOAD_WB: begin
            reg_write = 1'b1;
            wb_sel    = WB_MDR;
         end
         S_MEM_WR_REQ, S_MEM_WR_WAIT: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a = SRCA_A;
            alu_fct   = lt_q ? ALU_SLT : ALU_SUB;
            pc_src    = PCS_AOUT;
            pc_write  = (lt_q ? alu_lt : alu_zero) ^ neg_q;
         end
         S_JAL, S_JALR_JUMP: begin
            reg_write = 1'b1;
            wb_sel    = WB_PC;
            pc_write  = 1'b1;
            pc_src    = (state_q == S_JAL) ? PCS_AOUT : PCS_JALR;
         end
         S_LUI_WB: begin
            reg_write = 1'b1;
            wb_sel    = WB_IMM;
         end
         S_HALT: halted = 1'b1;
         default: ;
      endcase
   end

   assign state_out  = STATE_W'(state_q);
   assign trap_cause = trap_q;

`ifdef CTRL_PERF_CNT_EN
   logic [31:0] cyc_q, ret_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cyc_q <= '0;
         ret_q <= '0;
      end else begin
         if (state_q != S_HALT && state_q != S_TRAP) cyc_q <= cyc_q + 32'd1;
         if (state_d == S_FETCH_REQ && state_q != S_IDLE &&
             state_q != S_FETCH_REQ) ret_q <= ret_q + 32'd1;
      end
   end

   assign cyc_cnt = cyc_q;
   assign ret_cnt = ret_q;
`endif

endmodule
